sipo_deserializer: RTL and testbench

Serial-to-parallel receiver, the counterpart of the team's parallel-to-serial shifter. It samples a qualified LSB-first serial stream and assembles WIDTH-bit words. Each word is presented on a registered parallel output with a valid/ready handshake. It sits at the receiving end of the serial link and feeds word-oriented downstream logic.

---
 rtl/sipo_pkg.sv | 17 +
 rtl/sipo_deserializer_if.sv | 36 +++
 rtl/sipo_shifter.sv | 42 ++++
 rtl/sipo_deserializer.sv | 151 +++++++++++++++
 tb/tb_sipo_deserializer.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/sipo_pkg.sv
// Shared constants for the serial-to-parallel receiver: default word width,
// bit-counter sizing and FSM state encodings.
package sipo_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  // Counter must reach WIDTH so the parity phase can be told apart from the data bits.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial input / parallel output bundle of the receiver. parity_err_out only
// exists when DESER_PARITY_EN is defined.
interface sipo_deserializer_if
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             serial_in;
  logic             valid_in;
  logic             ready_in;
  logic [WIDTH-1:0] parallel_out;
  logic             valid_out;
  logic             busy_out;
  logic             overrun_out;
`ifdef DESER_PARITY_EN
  logic             parity_err_out;
`endif

  modport slave (
    input  serial_in, valid_in, ready_in,
`ifdef DESER_PARITY_EN
    output parity_err_out,
`endif
    output parallel_out, valid_out, busy_out, overrun_out
  );

  modport master (
    output serial_in, valid_in, ready_in,
`ifdef DESER_PARITY_EN
    input  parity_err_out,
`endif
    input  parallel_out, valid_out, busy_out, overrun_out
  );

endinterface

// File: rtl/sipo_shifter.sv
// Data shift register and bit counter: load writes bit_in at the position
// given by the counter and advances it; clear empties both.
module sipo_shifter
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             bit_in,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] data_r;
  logic [CNT_W-1:0] count_r;

  // Bit capture and position tracking; clear has priority over load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_r  <= '0;
      count_r <= '0;
    end else if (clear) begin
      data_r  <= '0;
      count_r <= '0;
    end else if (load) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (count_r == CNT_W'(i)) begin
          data_r[i] <= bit_in;
        end
      end
      count_r <= count_r + CNT_W'(1);
    end
  end

  assign data  = data_r;
  assign count = count_r;

endmodule

// File: rtl/sipo_deserializer.sv
// LSB-first serial-to-parallel receiver with a one-word registered output slot.
// Define DESER_PARITY_EN to expect an even-parity bit after each data word.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  sipo_deserializer_if.slave   bus
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state_r;
  logic [WIDTH-1:0] parallel_r;
  logic             valid_r;
  logic             busy_r;
  logic             overrun_r;
  logic             parity_err_r;

  logic [1:0]       state_nxt_s;
  logic             sh_clear_s;
  logic             sh_load_s;
  logic             complete_s;
  logic [WIDTH-1:0] sh_data_s;
  logic [CNT_W-1:0] sh_count_s;
  logic [WIDTH-1:0] word_s;
  logic             parity_err_s;

`ifdef DESER_PARITY_EN
  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction
`endif

  sipo_shifter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_shifter (
    .clk    (clk),
    .rst    (rst),
    .clear  (sh_clear_s),
    .load   (sh_load_s),
    .bit_in (bus.serial_in),
    .data   (sh_data_s),
    .count  (sh_count_s)
  );

  // Receive FSM: any gap in valid_in abandons the partial word without a flag.
  always_comb begin
    state_nxt_s = state_r;
    sh_clear_s  = 1'b0;
    sh_load_s   = 1'b0;
    complete_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.valid_in) begin
          sh_load_s   = 1'b1;
          state_nxt_s = ST_SHIFT;
        end else begin
          sh_clear_s  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!bus.valid_in) begin
          sh_clear_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (sh_count_s == LAST_BIT) begin
`ifdef DESER_PARITY_EN
          sh_load_s   = 1'b1;
          state_nxt_s = ST_PARITY;
`else
          complete_s  = 1'b1;
          sh_clear_s  = 1'b1;
          state_nxt_s = ST_IDLE;
`endif
        end else begin
          sh_load_s   = 1'b1;
        end
      end
      ST_PARITY: begin
        if (bus.valid_in) begin
          complete_s  = 1'b1;
        end else begin
          complete_s  = 1'b0;
        end
        sh_clear_s  = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        sh_clear_s  = 1'b1;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Completed word: without parity the last data bit is taken straight from the line.
  always_comb begin
    word_s       = sh_data_s;
    parity_err_s = 1'b0;
`ifdef DESER_PARITY_EN
    parity_err_s = even_parity(sh_data_s) ^ bus.serial_in;
`else
    word_s[WIDTH-1] = bus.serial_in;
`endif
  end

  // State and busy registers; busy tracks the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
    end
  end

  // Output slot: a word completing into an occupied, unaccepted slot is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parallel_r   <= '0;
      valid_r      <= 1'b0;
      overrun_r    <= 1'b0;
      parity_err_r <= 1'b0;
    end else if (complete_s && (!valid_r || bus.ready_in)) begin
      parallel_r   <= word_s;
      valid_r      <= 1'b1;
      parity_err_r <= parity_err_s;
    end else if (complete_s) begin
      overrun_r    <= 1'b1;
    end else if (valid_r && bus.ready_in) begin
      valid_r      <= 1'b0;
      parity_err_r <= 1'b0;
    end
  end

  assign bus.parallel_out = parallel_r;
  assign bus.valid_out    = valid_r;
  assign bus.busy_out     = busy_r;
  assign bus.overrun_out  = overrun_r;
`ifdef DESER_PARITY_EN
  assign bus.parity_err_out = parity_err_r;
`else
  logic unused_s;
  assign unused_s = parity_err_r ^ parity_err_s;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: per-cycle vector table plus hand
// sequences for power-on reset, async reset mid-word and DESER_PARITY_EN.
module tb_sipo_deserializer;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sipo_deserializer_if #(.WIDTH(W)) bus ();

  sipo_deserializer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic         rst;
    logic         valid;
    logic         serial;
    logic         ready;
    logic [W-1:0] po;
    logic         vo;
    logic         busy;
    logic         ov;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic r, input logic v, input logic s, input logic rd,
                     input logic [W-1:0] po, input logic vo, input logic b, input logic ov);
    vec_t t;
    t = '{r, v, s, rd, po, vo, b, ov};
    tbl.push_back(t);
  endtask

  task automatic check_out(input string name, input logic [W-1:0] po, input logic vo,
                           input logic b, input logic ov);
    n_vec++;
    if ({bus.parallel_out, bus.valid_out, bus.busy_out, bus.overrun_out} !== {po, vo, b, ov}) begin
      n_err++;
      $display("FAIL %s: got po=%h vo=%b busy=%b ov=%b, expected po=%h vo=%b busy=%b ov=%b",
               name, bus.parallel_out, bus.valid_out, bus.busy_out, bus.overrun_out,
               po, vo, b, ov);
    end
  endtask

  // Inputs change on the falling edge; outputs are read one full cycle later.
  task automatic step(input logic r, input logic v, input logic s, input logic rd);
    rst           = r;
    bus.valid_in  = v;
    bus.serial_in = s;
    bus.ready_in  = rd;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic rd, input logic bad_par);
    for (int i = 0; i < W; i++) step(1'b1, 1'b1, w[i], rd);
`ifdef DESER_PARITY_EN
    step(1'b1, 1'b1, (^w) ^ bad_par, rd);
`else
    if (bad_par) $display("note: parity bit not used in this build");
`endif
  endtask

  initial begin
    rst           = 1'b0;
    bus.valid_in  = 1'b0;
    bus.serial_in = 1'b0;
    bus.ready_in  = 1'b0;
    @(negedge clk);

    // Power-on reset with random inputs.
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
      check_out("reset_hold", 4'h0, 1'b0, 1'b0, 1'b0);
    end

`ifndef DESER_PARITY_EN
    // first word 4, back-to-back 4 and 5
    add(1,1,0,1, 4'h0,0,1,0); add(1,1,0,1, 4'h0,0,1,0); add(1,1,1,1, 4'h0,0,1,0); add(1,1,0,1, 4'h4,1,0,0);
    add(1,1,0,1, 4'h4,0,1,0); add(1,1,0,1, 4'h4,0,1,0); add(1,1,1,1, 4'h4,0,1,0); add(1,1,0,1, 4'h4,1,0,0);
    add(1,1,1,1, 4'h4,0,1,0); add(1,1,0,1, 4'h4,0,1,0); add(1,1,1,1, 4'h4,0,1,0); add(1,1,0,1, 4'h5,1,0,0);
    // stall: 4 then 5 with ready low -> overrun, slot keeps 4
    add(1,0,0,1, 4'h5,0,0,0);
    add(1,1,0,0, 4'h5,0,1,0); add(1,1,0,0, 4'h5,0,1,0); add(1,1,1,0, 4'h5,0,1,0); add(1,1,0,0, 4'h4,1,0,0);
    add(1,1,1,0, 4'h4,1,1,0); add(1,1,0,0, 4'h4,1,1,0); add(1,1,1,0, 4'h4,1,1,0); add(1,1,0,0, 4'h4,1,0,1);
    add(1,0,0,1, 4'h4,0,0,1);
    // reset clears sticky overrun, then abort after 2 bits and a full 0xA
    add(0,0,0,1, 4'h0,0,0,0);
    add(1,1,1,1, 4'h0,0,1,0); add(1,1,1,1, 4'h0,0,1,0); add(1,0,0,1, 4'h0,0,0,0);
    add(1,1,0,1, 4'h0,0,1,0); add(1,1,1,1, 4'h0,0,1,0); add(1,1,0,1, 4'h0,0,1,0); add(1,1,1,1, 4'hA,1,0,0);
    add(1,0,0,1, 4'hA,0,0,0);
    // 3 held, then 6 completes on the same edge 3 is accepted
    add(1,1,1,0, 4'hA,0,1,0); add(1,1,1,0, 4'hA,0,1,0); add(1,1,0,0, 4'hA,0,1,0); add(1,1,0,0, 4'h3,1,0,0);
    add(1,1,0,0, 4'h3,1,1,0); add(1,1,1,0, 4'h3,1,1,0); add(1,1,1,0, 4'h3,1,1,0); add(1,1,0,1, 4'h6,1,0,0);
    add(1,0,0,1, 4'h6,0,0,0);
    // abort right before the last data bit
    add(1,1,1,1, 4'h6,0,1,0); add(1,1,1,1, 4'h6,0,1,0); add(1,1,1,1, 4'h6,0,1,0); add(1,0,1,1, 4'h6,0,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].valid, tbl[i].serial, tbl[i].ready);
      check_out($sformatf("vec%0d", i), tbl[i].po, tbl[i].vo, tbl[i].busy, tbl[i].ov);
    end
`endif

    // Reset asserted mid-word acts immediately, without waiting for a clock edge.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check_out("midword_busy", 4'h0, 1'b0, 1'b1, 1'b0);
    #1 rst = 1'b0;
    #1 check_out("async_reset", 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    send_word(4'h5, 1'b1, 1'b0);
    check_out("after_reset_word", 4'h5, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check_out("after_reset_accept", 4'h5, 1'b0, 1'b0, 1'b0);

`ifdef DESER_PARITY_EN
    send_word(4'h5, 1'b1, 1'b0);
    check_out("par_good_word", 4'h5, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (bus.parity_err_out !== 1'b0) begin
      n_err++;
      $display("FAIL par_good: got parity_err=%b, expected 0", bus.parity_err_out);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1);
    send_word(4'h5, 1'b1, 1'b1);
    check_out("par_bad_word", 4'h5, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (bus.parity_err_out !== 1'b1) begin
      n_err++;
      $display("FAIL par_bad: got parity_err=%b, expected 1", bus.parity_err_out);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (bus.parity_err_out !== 1'b0 || bus.valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL par_clear: got parity_err=%b vo=%b, expected 0 0",
               bus.parity_err_out, bus.valid_out);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
